// File: rtl/cb_arbiter.sv
// rtl/cb_arbiter.sv - two-master (fetch, LSU) to one-slave core-bus read arbiter with in-order response routing
//
// Purpose:
//   Shares one core-bus port between instruction fetch and the LSU. Read
//   addresses are arbitrated (round-robin or LSU priority) and a grant is
//   held until the slave accepts it. Read responses are steered back to the
//   issuing master using a FIFO of master IDs. Write channels belong to the
//   LSU only and are passed straight through.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr_cb_mosi_i   fetch request (read fields only)
//   instr_cb_miso_o   fetch response (write fields tied to 0)
//   lsu_cb_mosi_i     LSU request
//   lsu_cb_miso_o     LSU response
//   cb_mosi_o         request to slave/interconnect
//   cb_miso_i         response from slave/interconnect
//   ot_cnt_o          outstanding reads held in the order FIFO
//   err_o             one-cycle pulse after a read response arrived with nothing outstanding

package cb_pkg;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic        wr_resp_valid;
    logic [1:0]  wr_resp;
  } s_cb_miso_t;

endpackage

module cb_arbiter
  import cb_pkg::*;
#(
  parameter int MAX_OT_TXN = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  s_cb_mosi_t                  instr_cb_mosi_i,
  output s_cb_miso_t                  instr_cb_miso_o,
  input  s_cb_mosi_t                  lsu_cb_mosi_i,
  output s_cb_miso_t                  lsu_cb_miso_o,
  output s_cb_mosi_t                  cb_mosi_o,
  input  s_cb_miso_t                  cb_miso_i,
  output logic [$clog2(MAX_OT_TXN):0] ot_cnt_o,
  output logic                        err_o
);

  localparam int CW = $clog2(MAX_OT_TXN) + 1;
  // A depth of 1 still needs a 1-bit pointer to index the ID array.
  localparam int PW = (MAX_OT_TXN > 1) ? $clog2(MAX_OT_TXN) : 1;
  localparam logic [CW-1:0] OT_MAX   = CW'(MAX_OT_TXN);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OT_TXN - 1);

  localparam logic [1:0] LK_NONE  = 2'd0;
  localparam logic [1:0] LK_INSTR = 2'd1;
  localparam logic [1:0] LK_LSU   = 2'd2;

  logic [1:0]    lock_ff, lock_nxt;
  logic          last_grant_ff;        // 0 = instr, 1 = LSU
  logic [CW-1:0] ot_cnt_ff;
  logic [PW-1:0] wr_ptr_ff, rd_ptr_ff;
  logic          id_mem [MAX_OT_TXN];  // 0 = instr, 1 = LSU
  logic          err_ff;

  logic instr_req, lsu_req, blocked, grant, win_lsu, addr_acc;
  logic fifo_empty, head_lsu, rsp_ready, push, pop, stray;

  // Fetch never writes; its write fields are intentionally ignored.
  logic unused_instr_fields;
  assign unused_instr_fields = ^instr_cb_mosi_i;

  always_comb begin
    instr_req = instr_cb_mosi_i.rd_addr_valid;
    lsu_req   = lsu_cb_mosi_i.rd_addr_valid;
    // Full is judged on the registered count so a same-cycle pop cannot
    // open a combinational rd_valid -> rd_addr_ready path.
    blocked   = (ot_cnt_ff == OT_MAX);
    win_lsu   = 1'b0;
    grant     = 1'b0;
    case (lock_ff)
      LK_INSTR: begin
        win_lsu = 1'b0;
        grant   = instr_req;
      end
      LK_LSU: begin
        win_lsu = 1'b1;
        grant   = lsu_req;
      end
      default: begin
        if (instr_req && lsu_req) begin
          win_lsu = (ARB_MODE == 1) ? 1'b1 : !last_grant_ff;
        end else begin
          win_lsu = lsu_req;
        end
        grant = instr_req || lsu_req;
      end
    endcase
    if (blocked) grant = 1'b0;
    addr_acc = grant && cb_miso_i.rd_addr_ready;
    push     = addr_acc;

    lock_nxt = lock_ff;
    if (lock_ff == LK_NONE) begin
      if (grant && !cb_miso_i.rd_addr_ready) lock_nxt = win_lsu ? LK_LSU : LK_INSTR;
    end else if (!grant || addr_acc) begin
      // Released on accept, or when the locked master withdraws its request.
      lock_nxt = LK_NONE;
    end

    fifo_empty = (ot_cnt_ff == '0);
    head_lsu   = id_mem[rd_ptr_ff];
    stray      = cb_miso_i.rd_valid && fifo_empty;
    // With nothing outstanding, any beat is drained so the slave cannot stall.
    if (fifo_empty) rsp_ready = cb_miso_i.rd_valid;
    else            rsp_ready = head_lsu ? lsu_cb_mosi_i.rd_ready : instr_cb_mosi_i.rd_ready;
    pop = cb_miso_i.rd_valid && rsp_ready && !fifo_empty;
  end

  always_comb begin
    cb_mosi_o               = lsu_cb_mosi_i;  // write fields pass through
    cb_mosi_o.rd_addr       = grant ? (win_lsu ? lsu_cb_mosi_i.rd_addr : instr_cb_mosi_i.rd_addr) : '0;
    cb_mosi_o.rd_size       = grant ? (win_lsu ? lsu_cb_mosi_i.rd_size : instr_cb_mosi_i.rd_size) : '0;
    cb_mosi_o.rd_addr_valid = grant;
    cb_mosi_o.rd_ready      = rsp_ready;

    instr_cb_miso_o               = '0;
    instr_cb_miso_o.rd_addr_ready = grant && !win_lsu && cb_miso_i.rd_addr_ready;
    instr_cb_miso_o.rd_valid      = cb_miso_i.rd_valid && !fifo_empty && !head_lsu;
    instr_cb_miso_o.rd_data       = (!fifo_empty && !head_lsu) ? cb_miso_i.rd_data : '0;
    instr_cb_miso_o.rd_resp       = (!fifo_empty && !head_lsu) ? cb_miso_i.rd_resp : '0;

    lsu_cb_miso_o               = '0;
    lsu_cb_miso_o.rd_addr_ready = grant && win_lsu && cb_miso_i.rd_addr_ready;
    lsu_cb_miso_o.rd_valid      = cb_miso_i.rd_valid && !fifo_empty && head_lsu;
    lsu_cb_miso_o.rd_data       = (!fifo_empty && head_lsu) ? cb_miso_i.rd_data : '0;
    lsu_cb_miso_o.rd_resp       = (!fifo_empty && head_lsu) ? cb_miso_i.rd_resp : '0;
    lsu_cb_miso_o.wr_addr_ready = cb_miso_i.wr_addr_ready;
    lsu_cb_miso_o.wr_data_ready = cb_miso_i.wr_data_ready;
    lsu_cb_miso_o.wr_resp_valid = cb_miso_i.wr_resp_valid;
    lsu_cb_miso_o.wr_resp       = cb_miso_i.wr_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_ff       <= LK_NONE;
      last_grant_ff <= 1'b0;
      ot_cnt_ff     <= '0;
      wr_ptr_ff     <= '0;
      rd_ptr_ff     <= '0;
      err_ff        <= 1'b0;
    end else begin
      lock_ff   <= lock_nxt;
      err_ff    <= stray;
      ot_cnt_ff <= ot_cnt_ff + CW'(push) - CW'(pop);
      if (push) begin
        last_grant_ff <= win_lsu;
        wr_ptr_ff     <= (wr_ptr_ff == PTR_LAST) ? '0 : wr_ptr_ff + PW'(1);
      end
      if (pop) begin
        rd_ptr_ff <= (rd_ptr_ff == PTR_LAST) ? '0 : rd_ptr_ff + PW'(1);
      end
    end
  end

  // ID storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_ff] <= win_lsu;
  end

  assign ot_cnt_o = ot_cnt_ff;
  assign err_o    = err_ff;

endmodule

// File: tb/tb_cb_arbiter.sv
// tb/tb_cb_arbiter.sv - scoreboard bench for cb_arbiter
module tb_cb_arbiter;
  import cb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s_cb_mosi_t instr_mosi, lsu_mosi, cb_mosi;
  s_cb_miso_t instr_miso, lsu_miso, cb_miso;
  logic [2:0] ot_cnt;
  logic       err;

  cb_arbiter #(.MAX_OT_TXN(4), .ARB_MODE(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_cb_mosi_i (instr_mosi),
    .instr_cb_miso_o (instr_miso),
    .lsu_cb_mosi_i   (lsu_mosi),
    .lsu_cb_miso_o   (lsu_miso),
    .cb_mosi_o       (cb_mosi),
    .cb_miso_i       (cb_miso),
    .ot_cnt_o        (ot_cnt),
    .err_o           (err)
  );

  typedef struct { bit id; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        sb[$];
  pend_t       sp[$];
  logic [31:0] iq[$], lq[$];
  bit          acc_log[$];

  int errors = 0, checks = 0;
  bit s_rdy = 1, resp_en = 1, i_rdy = 1, l_rdy = 1, stray = 0;
  int delay = 2, cyc = 0;
  int i_rsp = 0, l_rsp = 0, err_seen = 0, acc_cnt = 0, ot_peak = 0;
  logic [31:0] snap_cb_addr;
  bit snap_cb_valid, snap_cb_rdy, snap_i_ardy, snap_l_ardy, snap_i_rv, snap_l_rv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive masters/slave, observe at negedge, advance models after posedge.
  task automatic step();
    bit i_hs, l_hs, cb_hs, drain, real_rsp, i_rv, l_rv;
    logic [31:0] cb_addr_s;
    exp_t e;
    instr_mosi.rd_addr_valid = (iq.size() > 0);
    instr_mosi.rd_addr       = (iq.size() > 0) ? iq[0] : 32'h0;
    instr_mosi.rd_ready      = i_rdy;
    lsu_mosi.rd_addr_valid   = (lq.size() > 0);
    lsu_mosi.rd_addr         = (lq.size() > 0) ? lq[0] : 32'h0;
    lsu_mosi.rd_ready        = l_rdy;
    cb_miso.rd_addr_ready    = s_rdy;
    real_rsp = resp_en && (sp.size() > 0) && (sp.size() > 0 ? sp[0].due <= cyc : 1'b0);
    cb_miso.rd_valid = real_rsp || stray;
    cb_miso.rd_data  = real_rsp ? sp[0].addr + 32'hDEADBEEF : (stray ? 32'h5757_0000 : 32'h0);

    @(negedge clk);
    i_hs      = instr_mosi.rd_addr_valid && instr_miso.rd_addr_ready;
    l_hs      = lsu_mosi.rd_addr_valid && lsu_miso.rd_addr_ready;
    cb_hs     = cb_mosi.rd_addr_valid && cb_miso.rd_addr_ready;
    drain     = cb_miso.rd_valid && cb_mosi.rd_ready;
    cb_addr_s = cb_mosi.rd_addr;
    snap_cb_addr  = cb_mosi.rd_addr;
    snap_cb_valid = cb_mosi.rd_addr_valid;
    snap_cb_rdy   = cb_mosi.rd_ready;
    snap_i_ardy   = instr_miso.rd_addr_ready;
    snap_l_ardy   = lsu_miso.rd_addr_ready;
    snap_i_rv     = instr_miso.rd_valid;
    snap_l_rv     = lsu_miso.rd_valid;
    if (int'(ot_cnt) > ot_peak) ot_peak = int'(ot_cnt);
    if (err) err_seen++;

    if (i_hs || l_hs || cb_hs) begin
      check("hs_one_master", int'(i_hs) + int'(l_hs), 1);
      check("hs_slave", cb_hs, 1);
      check("hs_addr", cb_addr_s, i_hs ? iq[0] : lq[0]);
      if (i_hs) sb.push_back('{id: 1'b0, data: iq[0] + 32'hDEADBEEF});
      else if (l_hs) sb.push_back('{id: 1'b1, data: lq[0] + 32'hDEADBEEF});
      acc_log.push_back(l_hs);
      acc_cnt++;
    end

    if (instr_miso.rd_valid && lsu_miso.rd_valid) check("rsp_both_valid", 1, 0);
    i_rv = instr_miso.rd_valid && instr_mosi.rd_ready;
    l_rv = lsu_miso.rd_valid && lsu_mosi.rd_ready;
    if (i_rv || l_rv) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", l_rv, e.id);
        check("rsp_data", l_rv ? lsu_miso.rd_data : instr_miso.rd_data, e.data);
      end
      if (l_rv) l_rsp++;
      else i_rsp++;
    end

    @(posedge clk);
    #1;
    cyc++;
    if (i_hs) void'(iq.pop_front());
    if (l_hs) void'(lq.pop_front());
    if (drain && real_rsp) void'(sp.pop_front());
    if (cb_hs) sp.push_back('{addr: cb_addr_s, due: cyc - 1 + delay});
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((iq.size() + lq.size() + sp.size() + sb.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_idle"}, iq.size() + lq.size() + sp.size() + sb.size(), 0);
  endtask

  initial begin
    instr_mosi = '0;
    lsu_mosi   = '0;
    cb_miso    = '0;
    lsu_mosi.wr_addr       = 32'h100;
    lsu_mosi.wr_data       = 32'h55;
    lsu_mosi.wr_strobe     = 4'hF;
    lsu_mosi.wr_addr_valid = 1'b1;
    lsu_mosi.wr_data_valid = 1'b1;
    cb_miso.wr_addr_ready  = 1'b1;
    cb_miso.wr_resp_valid  = 1'b1;
    cb_miso.wr_resp        = 2'b10;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_ot_cnt", ot_cnt, 0);
    check("rst_err", err, 0);
    check("rst_rd_addr_valid", cb_mosi.rd_addr_valid, 0);
    check("rst_rd_addr", cb_mosi.rd_addr, 0);
    check("rst_rd_ready", cb_mosi.rd_ready, 0);
    check("rst_wr_addr_pass", cb_mosi.wr_addr, 32'h100);
    rst = 1'b0;
    step();

    // Fetch-only stream with concurrent LSU write traffic
    i_rsp = 0; l_rsp = 0; ot_peak = 0;
    iq = '{32'h0, 32'h4, 32'h8, 32'hC};
    step();
    step();
    check("wr_addr_pass", cb_mosi.wr_addr, 32'h100);
    check("wr_data_pass", cb_mosi.wr_data, 32'h55);
    check("wr_strobe_pass", cb_mosi.wr_strobe, 4'hF);
    check("wr_valid_pass", {cb_mosi.wr_addr_valid, cb_mosi.wr_data_valid}, 2'b11);
    check("wr_ready_back", lsu_miso.wr_addr_ready, 1);
    check("wr_resp_back", lsu_miso.wr_resp, 2'b10);
    check("instr_wr_zero", instr_miso.wr_addr_ready, 0);
    run_idle("fetch", 40);
    check("fetch_instr_rsp", i_rsp, 4);
    check("fetch_lsu_rsp", l_rsp, 0);
    check("fetch_ot_peak", ot_peak, 2);
    check("fetch_ot_end", ot_cnt, 0);

    // Round-robin under constant contention: L, I, L, I ...
    acc_log.delete(); i_rsp = 0; l_rsp = 0;
    iq = '{32'h20, 32'h24, 32'h28, 32'h2C};
    lq = '{32'h1000_0020, 32'h1000_0024, 32'h1000_0028, 32'h1000_002C};
    run_idle("rr", 60);
    check("rr_accepts", acc_log.size(), 8);
    for (int i = 0; i < acc_log.size(); i++) check("rr_order", acc_log[i], (i % 2 == 0) ? 1 : 0);
    check("rr_rsp_counts", {i_rsp[7:0], l_rsp[7:0]}, {8'd4, 8'd4});

    // Grant lock while slave stalls the address
    acc_log.delete();
    s_rdy = 1'b0;
    iq = '{32'h40};
    step();
    lq.push_back(32'h1000_0040);
    for (int k = 0; k < 2; k++) begin
      step();
      check("lock_addr", snap_cb_addr, 32'h40);
      check("lock_valid", snap_cb_valid, 1);
      check("lock_lsu_ardy", snap_l_ardy, 0);
    end
    s_rdy = 1'b1;
    step();
    check("lock_first_acc", {acc_log.size() == 1, acc_log.size() > 0 ? acc_log[0] : 1'b1}, 2'b10);
    step();
    check("lock_second_acc", {acc_log.size() == 2, acc_log.size() > 1 ? acc_log[1] : 1'b0}, 2'b11);
    run_idle("lock", 40);

    // Outstanding limit: no responses, six requests
    resp_en = 1'b0; acc_cnt = 0;
    iq = '{32'h60, 32'h64, 32'h68};
    lq = '{32'h1000_0060, 32'h1000_0064, 32'h1000_0068};
    repeat (10) step();
    check("full_accepts", acc_cnt, 4);
    check("full_ot_cnt", ot_cnt, 4);
    check("full_ardy", {snap_i_ardy, snap_l_ardy}, 2'b00);
    resp_en = 1'b1;
    step();
    check("full_pop_no_grant", acc_cnt, 4);
    step();
    check("full_fifth_acc", acc_cnt, 5);
    run_idle("full", 60);

    // Head master back-pressure, then release
    i_rsp = 0;
    i_rdy = 1'b0;
    iq = '{32'h0};
    repeat (4) step();
    check("hold_rv", snap_i_rv, 1);
    check("hold_cb_rdy", snap_cb_rdy, 0);
    check("hold_ot", ot_cnt, 1);
    check("hold_no_rsp", i_rsp, 0);
    i_rdy = 1'b1;
    step();
    check("release_rsp", i_rsp, 1);
    repeat (2) step();
    check("release_once", i_rsp, 1);
    check("release_ot", ot_cnt, 0);

    // Stray response with nothing outstanding
    err_seen = 0; i_rsp = 0; l_rsp = 0;
    stray = 1'b1;
    step();
    check("stray_drain", snap_cb_rdy, 1);
    check("stray_no_rv", {snap_i_rv, snap_l_rv}, 2'b00);
    stray = 1'b0;
    repeat (2) step();
    check("stray_err_pulse", err_seen, 1);
    check("stray_no_rsp", i_rsp + l_rsp, 0);

    // Reset with a read outstanding
    resp_en = 1'b0; err_seen = 0;
    iq = '{32'hA0};
    repeat (2) step();
    check("mid_ot_before", ot_cnt, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_ot_after", ot_cnt, 0);
    sb.delete();
    resp_en = 1'b1;
    repeat (3) step();
    check("mid_err", err_seen, 1);
    check("mid_drained", sp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
